// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared types and encodings for the MIPS multicycle control path.
package mips_multicycle_ctrl_pkg;

    // Controller states
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        ADDIEX = 4'd8,
        ADDIWB = 4'd9,
        BRANCH = 4'd10,
        JUMP   = 4'd11,
        ERROR  = 4'd12
    } ctrl_state_t;

    // Opcode field IR[31:26]. This is a plain vector because illegal
    // values must be representable.
    typedef logic [5:0] opcode_t;

    localparam opcode_t OP_RTYPE = 6'b000000;
    localparam opcode_t OP_J     = 6'b000010;
    localparam opcode_t OP_BEQ   = 6'b000100;
    localparam opcode_t OP_ADDI  = 6'b001000;
    localparam opcode_t OP_LW    = 6'b100011;
    localparam opcode_t OP_SW    = 6'b101011;

    // ALU operation class handed to the ALU decoder
    typedef enum logic [1:0] {
        ADD_Op    = 2'd0,
        SUB_Op    = 2'd1,
        R_Type_Op = 2'd2,
        ERR_Op    = 2'd3
    } alu_op_t;

    // pc_src mux encodings
    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    // alu_src_b mux encodings
    localparam logic [1:0] SRCB_REGB    = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

    // Raw per-state control word. ir_write, pc_write and done are
    // qualified by the memory handshake in the top level.
    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       branch;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        alu_op_t    alu_op;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       done;
        logic       err;
    } mc_ctrl_t;

endpackage

// File: rtl/mips_multicycle_ctrl_out_decode.sv
// Combinational state -> control word decoder for the multicycle controller.
module mips_ctrl_out_decode
    import mips_multicycle_ctrl_pkg::*;
(
    input  ctrl_state_t state,
    output mc_ctrl_t    ctrl
);

    // Moore decode: everything idle unless the state asks for it
    always_comb begin
        ctrl        = '0;
        ctrl.alu_op = ADD_Op;
        case (state)
            FETCH: begin
                ctrl.mem_req   = 1'b1;
                ctrl.iord      = 1'b0;
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
                ctrl.pc_src    = PC_SRC_ALU;
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_FOUR;
            end
            DECODE: begin
                // Branch target precomputed while the opcode is decoded
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_IMM_SH2;
            end
            MEMADR, ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            MEMRD: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b1;
            end
            MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.done       = 1'b1;
            end
            MEMWR: begin
                ctrl.mem_req = 1'b1;
                ctrl.mem_we  = 1'b1;
                ctrl.iord    = 1'b1;
                ctrl.done    = 1'b1;
            end
            EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REGB;
                ctrl.alu_op    = R_Type_Op;
            end
            ALUWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                ctrl.done      = 1'b1;
            end
            ADDIWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.done      = 1'b1;
            end
            BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REGB;
                ctrl.alu_op    = SUB_Op;
                ctrl.branch    = 1'b1;
                ctrl.pc_src    = PC_SRC_ALUOUT;
                ctrl.done      = 1'b1;
            end
            JUMP: begin
                ctrl.pc_write = 1'b1;
                ctrl.pc_src   = PC_SRC_JUMP;
                ctrl.alu_op   = ERR_Op;
                ctrl.done     = 1'b1;
            end
            ERROR: begin
                ctrl.err = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: state register, sequencing, memory
// handshake qualification and retired-instruction counter.
module mips_multicycle_ctrl
    import mips_multicycle_ctrl_pkg::*;
#(
    parameter int RETIRE_CNT_W = 32,
    parameter bit HALT_ON_ERR  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  opcode_t                 opcode,
    input  logic                    zero,
    input  logic                    mem_ready,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic                    iord,
    output logic                    ir_write,
    output logic                    pc_en,
    output logic [1:0]              pc_src,
    output logic                    alu_src_a,
    output logic [1:0]              alu_src_b,
    output alu_op_t                 alu_op,
    output logic                    reg_write,
    output logic                    reg_dst,
    output logic                    mem_to_reg,
    output logic                    instr_done,
    output logic                    err_illegal,
    output logic [RETIRE_CNT_W-1:0] retired_cnt
);

    ctrl_state_t             state_q, state_d;
    logic [RETIRE_CNT_W-1:0] retired_cnt_q, retired_cnt_d;
    mc_ctrl_t                ctrl;
    logic                    hs_ok;

    mips_ctrl_out_decode u_out_decode (
        .state (state_q),
        .ctrl  (ctrl)
    );

    // State and counter registers; reset wins over every transition
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FETCH;
            retired_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            retired_cnt_q <= retired_cnt_d;
        end
    end

    // Handshake qualification, next state and counter update
    always_comb begin
        // A state that requests memory only makes progress once the
        // access completes; states without a request always progress.
        hs_ok         = !ctrl.mem_req || mem_ready;
        instr_done    = ctrl.done && hs_ok;
        retired_cnt_d = retired_cnt_q + (instr_done ? RETIRE_CNT_W'(1) : '0);
        state_d       = state_q;
        case (state_q)
            FETCH:  if (mem_ready) state_d = DECODE;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXEC;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default:      state_d = ERROR;
                endcase
            end
            MEMADR: state_d = (opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD:  if (mem_ready) state_d = MEMWB;
            EXEC:   state_d = ALUWB;
            ADDIEX: state_d = ADDIWB;
            ERROR:  state_d = HALT_ON_ERR ? ERROR : FETCH;
            default: ;
        endcase
        // Every completing state returns to fetch
        if (instr_done) state_d = FETCH;
    end

    // Output drive
    always_comb begin
        mem_req     = ctrl.mem_req;
        mem_we      = ctrl.mem_we;
        iord        = ctrl.iord;
        ir_write    = ctrl.ir_write && hs_ok;
        pc_en       = (ctrl.pc_write && hs_ok) || (ctrl.branch && zero);
        pc_src      = ctrl.pc_src;
        alu_src_a   = ctrl.alu_src_a;
        alu_src_b   = ctrl.alu_src_b;
        alu_op      = ctrl.alu_op;
        reg_write   = ctrl.reg_write;
        reg_dst     = ctrl.reg_dst;
        mem_to_reg  = ctrl.mem_to_reg;
        err_illegal = ctrl.err;
        retired_cnt = retired_cnt_q;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Multicycle control FSM for the MIPS core. It sequences a shared-memory multicycle datapath (PC, IR, register file, ALU, single instruction/data memory port) through fetch, decode, execute, memory and writeback. It supports the core ISA subset: R-type, LW, SW, BEQ, ADDI and J. Memory accesses use a req/ready handshake so that slow memory stalls the FSM.

Parameters:
RETIRE_CNT_W, 32, width of the retired-instruction counter.
HALT_ON_ERR, 1, 1: an illegal opcode parks the FSM in ERROR until reset; 0: it flags err_illegal for one cycle and returns to FETCH.

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
opcode  in  6 (opcode_t)  IR[31:26], valid from DECODE onward
zero  in  1  ALU zero flag
mem_ready  in  1  memory accepted/completed the current access
mem_req  out  1  memory access request
mem_we  out  1  write enable qualifying mem_req
iord  out  1  0: address=PC, 1: address=ALUOut
ir_write  out  1  latch IR from memory read data
pc_en  out  1  PC load = pc_write | (branch & zero)
pc_src  out  2  0: ALU result, 1: ALUOut, 2: jump target
alu_src_a  out  1  0: PC, 1: reg A
alu_src_b  out  2  0: reg B, 1: const 4, 2: sign-extended imm, 3: sign-extended imm<<2
alu_op  out  alu_op_t  ALU operation class
reg_write  out  1  register file write
reg_dst  out  1  0: rt, 1: rd
mem_to_reg  out  1  0: ALUOut, 1: MDR
instr_done  out  1  one-cycle pulse on the last cycle of each instruction
err_illegal  out  1  illegal opcode flag
retired_cnt  out  RETIRE_CNT_W  count of completed instructions

Behaviour:
- Reset: state=FETCH, retired_cnt=0, err_illegal=0. All outputs are decoded from state (Moore, plus mem_ready/zero gating). In FETCH the outputs are mem_req=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=ADD_Op, pc_src=0. Every other output is 0.
- FETCH: hold while mem_ready=0. On mem_ready=1, assert ir_write=1 and pc_write=1 (PC+4) in that same cycle, then go to DECODE. ir_write and pc_write are gated by mem_ready.
- DECODE: alu_src_a=0, alu_src_b=3, alu_op=ADD_Op to precompute the branch target. Transitions:
  - LW/SW go to MEMADR.
  - R-type goes to EXEC.
  - BEQ goes to BRANCH.
  - ADDI goes to ADDIEX.
  - J goes to JUMP.
  - Any other opcode goes to ERROR.
- MEMADR: alu_src_a=1, alu_src_b=2, ADD_Op. LW goes to MEMRD; SW goes to MEMWR.
- MEMRD: mem_req=1, iord=1. Hold until mem_ready, then go to MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1. Instruction done.
- MEMWR: mem_req=1, mem_we=1, iord=1. Hold until mem_ready. Instruction done on the cycle mem_ready=1.
- EXEC: alu_src_a=1, alu_src_b=0, alu_op=R_Type_Op. Goes to ALUWB.
- ALUWB: reg_write=1, reg_dst=1. Instruction done.
- ADDIEX: alu_src_a=1, alu_src_b=2, ADD_Op. Goes to ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0. Instruction done.
- BRANCH: alu_src_a=1, alu_src_b=0, alu_op=SUB_Op, branch=1, pc_src=1. pc_en=zero. Instruction done.
- JUMP: pc_write=1, pc_src=2, alu_op=ERR_Op. Instruction done.
- Instruction completion: on the instruction-done cycle, instr_done=1, retired_cnt increments (wraps at 2^RETIRE_CNT_W without flagging), and the next state is FETCH.
- ERROR, HALT_ON_ERR=1:
  - The FSM stays in ERROR and err_illegal=1 is sticky.
  - No mem_req, reg_write or pc_en is issued.
  - retired_cnt does not increment.
- ERROR, HALT_ON_ERR=0: err_illegal=1 for one cycle, then FETCH. The PC is already advanced, so the instruction is skipped.
- Instruction latencies with zero-wait memory (mem_ready tied 1):
  - LW: 5 cycles.
  - SW, R-type, ADDI: 4 cycles.
  - BEQ, J: 3 cycles.
  - Each memory wait cycle adds one cycle.
- mem_req stays asserted and stable (address/we unchanged) until mem_ready. mem_ready outside FETCH, MEMRD and MEMWR is ignored.
- rst has priority over every transition. Reset mid-access drops mem_req on the next edge.
- Sign extension and shifts belong to the datapath; this block only selects them.

Decomposition:
- Shared package holds:
  - ctrl_state_t enum (FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, ADDIEX, ADDIWB, BRANCH, JUMP, ERROR).
  - Existing opcode_t and alu_op_t with the opcode constants.
  - mc_ctrl_t packed struct bundling the datapath control outputs.
  - Constants for the pc_src and alu_src_b encodings.
- Sub-module mips_ctrl_out_decode is purely combinational: state -> mc_ctrl_t. The top module keeps the state register, next-state logic, handshake gating and counter.

Test Plan:
1. LW (opcode 100011), mem_ready=1 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; reg_write=1 and mem_to_reg=1 in cycle 5; retired_cnt 0->1.
2. SW with mem_ready low for 3 cycles in MEMWR -> mem_req=1, mem_we=1, iord=1 held stable for 4 cycles; instr_done only on the cycle mem_ready=1; no reg_write.
3. BEQ with zero=1, then BEQ with zero=0 -> pc_en=1 and pc_src=1 in BRANCH for the first; pc_en=0 for the second; both take 3 cycles.
4. R-type then ADDI back-to-back -> reg_dst=1 in ALUWB, reg_dst=0 in ADDIWB, alu_op=R_Type_Op in EXEC; retired_cnt=2 after 8 cycles.
5. Opcode 111111, HALT_ON_ERR=1 -> ERROR entered after DECODE; err_illegal stays 1 for 20+ cycles; no mem_req; rst=1 returns to FETCH with err_illegal=0. With HALT_ON_ERR=0 -> one-cycle err_illegal pulse, then FETCH.
6. rst asserted during MEMRD wait -> next cycle state=FETCH, mem_req reflects FETCH, retired_cnt=0; with RETIRE_CNT_W=4 after 16 J instructions, retired_cnt wraps to 0.
